// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Stage indices address the internal enable/flush vectors in pipeline order.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } ctrl_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int STG_PC     = 0;
    localparam int STG_IF_ID  = 1;
    localparam int STG_ID_EX  = 2;
    localparam int STG_EX_MEM = 3;
    localparam int STG_MEM_WB = 4;
    localparam int NUM_STAGES = 5;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, taken-branch
// flushes and data-memory wait freezes with a timeout into a sticky error state.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch_taken,
    input  logic             mem_access,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mem_wb_flush,
    output logic             halted,
    output logic             bus_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WC_W = $clog2(MEM_TIMEOUT);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

    ctrl_state_e state_q, state_d;
    logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;

    logic [NUM_STAGES-1:0] en_c;
    logic [NUM_STAGES-1:1] flush_c;
    logic                  load_use;
    logic                  br_evt;
    logic                  stall_inc;
    logic                  flush_inc;

    assign load_use = ex_mem_read && (ex_rt != REG_ZERO) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        en_c       = '1;
        flush_c    = '0;
        br_evt     = 1'b0;

        unique case (state_q)
            ST_RUN, ST_MEM_WAIT: begin
                if ((state_q == ST_RUN) ? (mem_access && !dmem_ready) : !dmem_ready) begin
                    // Freeze everything upstream of MEM; WB takes a bubble so the
                    // stalled instruction in MEM does not retire twice.
                    en_c[STG_PC]         = 1'b0;
                    en_c[STG_IF_ID]      = 1'b0;
                    en_c[STG_ID_EX]      = 1'b0;
                    en_c[STG_EX_MEM]     = 1'b0;
                    flush_c[STG_MEM_WB]  = 1'b1;
                    if (state_q == ST_RUN) begin
                        state_d    = ST_MEM_WAIT;
                        wait_cnt_d = WC_W'(1);
                    end else if (wait_cnt_q == WC_LAST) begin
                        state_d    = ST_ERR;
                        wait_cnt_d = '0;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WC_W'(1);
                    end
                end else begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                    // A taken branch squashes the younger instruction, so it
                    // takes precedence over a load-use stall on that instruction.
                    if (ex_branch_taken) begin
                        flush_c[STG_IF_ID] = 1'b1;
                        flush_c[STG_ID_EX] = 1'b1;
                        br_evt             = 1'b1;
                    end else if (load_use) begin
                        en_c[STG_PC]       = 1'b0;
                        en_c[STG_IF_ID]    = 1'b0;
                        flush_c[STG_ID_EX] = 1'b1;
                    end
                end
            end
            ST_ERR: begin
                en_c = '0;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase

        // Stage registers have no reset; hold them in flush while rst_n is low.
        if (!rst_n) begin
            en_c    = '0;
            flush_c = '1;
            br_evt  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign stall_inc = rst_n && !en_c[STG_PC];
    assign flush_inc = br_evt;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .q     (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc),
        .q     (flush_count)
    );

    assign pc_en        = en_c[STG_PC];
    assign if_id_en     = en_c[STG_IF_ID];
    assign id_ex_en     = en_c[STG_ID_EX];
    assign ex_mem_en    = en_c[STG_EX_MEM];
    assign mem_wb_en    = en_c[STG_MEM_WB];
    assign if_id_flush  = flush_c[STG_IF_ID];
    assign id_ex_flush  = flush_c[STG_ID_EX];
    assign ex_mem_flush = flush_c[STG_EX_MEM];
    assign mem_wb_flush = flush_c[STG_MEM_WB];
    assign halted       = (state_q == ST_ERR);
    assign bus_err      = (state_q == ST_ERR);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: reset, load-use, branch, memory wait,
// timeout into error, and reset during a memory wait.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rt, ex_mem_read, ex_branch_taken, mem_access, dmem_ready;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic        halted, bus_err;
    logic [15:0] stall_cycles, flush_count;

    logic [4:0]  en;
    logic [3:0]  fl;
    int          total = 0;
    int          bad   = 0;

    assign en = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};
    assign fl = {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .ex_mem_read     (ex_mem_read),
        .ex_rt           (ex_rt),
        .ex_branch_taken (ex_branch_taken),
        .mem_access      (mem_access),
        .dmem_ready      (dmem_ready),
        .pc_en           (pc_en),
        .if_id_en        (if_id_en),
        .id_ex_en        (id_ex_en),
        .ex_mem_en       (ex_mem_en),
        .mem_wb_en       (mem_wb_en),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_flush    (ex_mem_flush),
        .mem_wb_flush    (mem_wb_flush),
        .halted          (halted),
        .bus_err         (bus_err),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
    );

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
        id_uses_rt = 1'b0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
        mem_access = 1'b0; dmem_ready = 1'b1;
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        @(negedge clk);
        total++;
        if (en !== 5'b00000 || fl !== 4'b1111) begin
            bad++;
            $display("FAIL reset_outputs: en=%b fl=%b want en=00000 fl=1111", en, fl);
        end
        total++;
        if (stall_cycles !== 16'd0 || flush_count !== 16'd0 || halted !== 1'b0 || bus_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: stall=%0d flush=%0d halted=%b bus_err=%b want 0 0 0 0",
                     stall_cycles, flush_count, halted, bus_err);
        end
        step();
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (en !== 5'b11111 || fl !== 4'b0000) begin
            bad++;
            $display("FAIL reset_release: en=%b fl=%b want en=11111 fl=0000", en, fl);
        end
        step();
    endtask

    task automatic test_load_use();
        ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        @(negedge clk);
        total++;
        if (en !== 5'b00111 || fl !== 4'b0100) begin
            bad++;
            $display("FAIL load_use_rs: en=%b fl=%b want en=00111 fl=0100", en, fl);
        end
        step();
        ex_mem_read = 1'b0;
        @(negedge clk);
        total++;
        if (en !== 5'b11111 || fl !== 4'b0000 || stall_cycles !== 16'd1) begin
            bad++;
            $display("FAIL load_use_bubble: en=%b fl=%b stall=%0d want en=11111 fl=0000 stall=1",
                     en, fl, stall_cycles);
        end
        step();
        ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        @(negedge clk);
        total++;
        if (en !== 5'b11111 || fl !== 4'b0000) begin
            bad++;
            $display("FAIL load_use_r0: en=%b fl=%b want en=11111 fl=0000", en, fl);
        end
        step();
        ex_rt = 5'd7; id_rs = 5'd3; id_rt = 5'd7; id_uses_rt = 1'b1;
        @(negedge clk);
        total++;
        if (en !== 5'b00111 || fl !== 4'b0100) begin
            bad++;
            $display("FAIL load_use_rt: en=%b fl=%b want en=00111 fl=0100", en, fl);
        end
        step();
        id_uses_rt = 1'b0;
        @(negedge clk);
        total++;
        if (en !== 5'b11111 || stall_cycles !== 16'd2) begin
            bad++;
            $display("FAIL load_use_rt_unused: en=%b stall=%0d want en=11111 stall=2", en, stall_cycles);
        end
        step();
        idle();
    endtask

    task automatic test_branch_load_use();
        ex_mem_read = 1'b1; ex_rt = 5'd9; id_rs = 5'd9; ex_branch_taken = 1'b1;
        @(negedge clk);
        total++;
        if (en !== 5'b11111 || fl !== 4'b1100) begin
            bad++;
            $display("FAIL branch_override: en=%b fl=%b want en=11111 fl=1100", en, fl);
        end
        step();
        idle();
        @(negedge clk);
        total++;
        if (flush_count !== 16'd1 || stall_cycles !== 16'd2) begin
            bad++;
            $display("FAIL branch_count: flush=%0d stall=%0d want flush=1 stall=2", flush_count, stall_cycles);
        end
        step();
    endtask

    task automatic test_mem_wait();
        int errs;
        errs = 0;
        mem_access = 1'b1; dmem_ready = 1'b0; ex_branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (en !== 5'b00001 || fl !== 4'b0001) errs++;
            step();
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL mem_wait_freeze: %0d bad frozen cycles want 0", errs);
        end
        dmem_ready = 1'b1;
        @(negedge clk);
        total++;
        if (en !== 5'b11111 || fl !== 4'b1100) begin
            bad++;
            $display("FAIL mem_wait_release: en=%b fl=%b want en=11111 fl=1100", en, fl);
        end
        step();
        idle();
        @(negedge clk);
        total++;
        if (stall_cycles !== 16'd5 || flush_count !== 16'd2 || halted !== 1'b0) begin
            bad++;
            $display("FAIL mem_wait_counts: stall=%0d flush=%0d halted=%b want 5 2 0",
                     stall_cycles, flush_count, halted);
        end
        step();
    endtask

    task automatic test_back_to_back();
        mem_access = 1'b1; dmem_ready = 1'b0;
        step();
        dmem_ready = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd4; id_rs = 5'd4;
        @(negedge clk);
        total++;
        if (en !== 5'b00111 || fl !== 4'b0100) begin
            bad++;
            $display("FAIL release_load_use: en=%b fl=%b want en=00111 fl=0100", en, fl);
        end
        step();
        idle();
        @(negedge clk);
        total++;
        if (en !== 5'b11111 || stall_cycles !== 16'd7) begin
            bad++;
            $display("FAIL back_to_back: en=%b stall=%0d want en=11111 stall=7", en, stall_cycles);
        end
        step();
    endtask

    task automatic test_timeout();
        int errs;
        errs = 0;
        mem_access = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (en !== 5'b00001 || fl !== 4'b0001 || halted !== 1'b0 || bus_err !== 1'b0) errs++;
            step();
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL timeout_wait: %0d bad wait cycles want 0", errs);
        end
        mem_access = 1'b0; dmem_ready = 1'b1;
        @(negedge clk);
        total++;
        if (halted !== 1'b1 || bus_err !== 1'b1 || en !== 5'b00000 || fl !== 4'b0000 || stall_cycles !== 16'd23) begin
            bad++;
            $display("FAIL timeout_err: halted=%b bus_err=%b en=%b fl=%b stall=%0d want 1 1 00000 0000 23",
                     halted, bus_err, en, fl, stall_cycles);
        end
        step();
        step();
        @(negedge clk);
        total++;
        if (halted !== 1'b1 || stall_cycles !== 16'd25) begin
            bad++;
            $display("FAIL err_sticky: halted=%b stall=%0d want halted=1 stall=25", halted, stall_cycles);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (halted !== 1'b0 || bus_err !== 1'b0 || fl !== 4'b1111 || stall_cycles !== 16'd0 || flush_count !== 16'd0) begin
            bad++;
            $display("FAIL err_reset: halted=%b bus_err=%b fl=%b stall=%0d flush=%0d want 0 0 1111 0 0",
                     halted, bus_err, fl, stall_cycles, flush_count);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset_mid_wait();
        int errs;
        errs = 0;
        mem_access = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 5; i++) step();
        @(negedge clk);
        total++;
        if (stall_cycles !== 16'd5 || en !== 5'b00001) begin
            bad++;
            $display("FAIL mid_wait_pre: stall=%0d en=%b want stall=5 en=00001", stall_cycles, en);
        end
        step();
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if (en !== 5'b00000 || fl !== 4'b1111 || stall_cycles !== 16'd0) begin
            bad++;
            $display("FAIL mid_wait_reset: en=%b fl=%b stall=%0d want 00000 1111 0", en, fl, stall_cycles);
        end
        step();
        rst_n = 1'b1;
        idle();
        @(negedge clk);
        total++;
        if (en !== 5'b11111 || fl !== 4'b0000 || halted !== 1'b0) begin
            bad++;
            $display("FAIL mid_wait_run: en=%b fl=%b halted=%b want 11111 0000 0", en, fl, halted);
        end
        step();
        // A fresh wait must again last a full 16 cycles before the error.
        mem_access = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (halted !== 1'b0) errs++;
        end
        step();
        total++;
        if (errs != 0 || halted !== 1'b1) begin
            bad++;
            $display("FAIL mid_wait_fresh_timeout: early=%0d halted=%b want early=0 halted=1", errs, halted);
        end
        rst_n = 1'b0;
        idle();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_load_use();
        test_mem_wait();
        test_back_to_back();
        test_timeout();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
